// File: rtl/roic_link_cal_ctrl.sv
// Calibration sequencer for one TI-ROIC LVDS lane: runs bit alignment, qualifies lock through
// repeated first-channel detections, retries on failure and re-calibrates a locked link that drops.
module roic_link_cal_ctrl #(
  parameter int START_PULSE_W  = 2,
  parameter int ALIGN_TIMEOUT  = 1024,
  parameter int DETECT_TIMEOUT = 4096,
  parameter int LOCK_CHECKS    = 4,
  parameter int MAX_RETRY      = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cal_req,
  input  logic       i_manual_mode,
  input  logic [4:0] i_manual_shift,
  input  logic       i_align_done,
  input  logic [4:0] i_shift_in,
  input  logic       i_channel_detected,
  output logic       o_align_start,
  output logic       o_align_to_fclk,
  output logic [4:0] o_extra_shift,
  output logic       o_locked,
  output logic       o_cal_fail,
  output logic       o_busy,
  output logic       o_lost_lock,
  output logic [2:0] o_retry_cnt,
  output logic [2:0] o_dbg_state
);

  localparam int TMAX = (ALIGN_TIMEOUT > DETECT_TIMEOUT) ? ALIGN_TIMEOUT : DETECT_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int PCW  = (START_PULSE_W > 1) ? $clog2(START_PULSE_W) : 1;
  localparam int GW   = (LOCK_CHECKS > 1) ? $clog2(LOCK_CHECKS) : 1;

  localparam logic [TW-1:0]  ALIGN_LAST = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [TW-1:0]  DET_LAST   = TW'(DETECT_TIMEOUT - 1);
  localparam logic [TW-1:0]  TIMER_SAT  = {TW{1'b1}};
  localparam logic [PCW-1:0] PW_LAST    = PCW'(START_PULSE_W - 1);
  localparam logic [GW-1:0]  GOOD_LAST  = GW'(LOCK_CHECKS - 1);
  localparam logic [2:0]     RETRY_MAX  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_WAIT_ALIGN = 3'd2,
    S_WAIT_DET   = 3'd3,
    S_VERIFY     = 3'd4,
    S_LOCKED     = 3'd5,
    S_RETRY      = 3'd6,
    S_FAIL       = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_timer;
  logic [PCW-1:0]   r_pulse_cnt;
  logic [GW-1:0]    r_good_cnt;
  logic             r_seen_low;
  logic [4:0]       r_ref_shift;

  logic             w_good;
  logic             w_fault;
  logic             w_det_to;
  logic             w_align_to;
  logic             w_lost;
  logic             w_fresh;
  logic             w_timer_run;

  logic             w_align_start_nxt;
  logic             w_align_to_fclk_nxt;
  logic [4:0]       w_extra_shift_nxt;
  logic             w_locked_nxt;
  logic             w_cal_fail_nxt;
  logic             w_busy_nxt;
  logic             w_lost_lock_nxt;
  logic [2:0]       w_retry_nxt;

  // Alignment handshake: align_start is a START_PULSE_W-cycle request; completion is accepted
  // only as a low-to-high sequence of align_done seen inside WAIT_ALIGN, so a done left over
  // from an earlier run can never complete a new attempt.
  assign w_good     = i_channel_detected && i_align_done && (i_shift_in == r_ref_shift);
  assign w_fault    = !i_align_done || (i_shift_in != r_ref_shift);
  assign w_det_to   = (r_timer == DET_LAST);
  assign w_align_to = (r_timer == ALIGN_LAST);
  assign w_lost     = (r_state == S_LOCKED) && !w_good && (w_fault || w_det_to);
  assign w_fresh    = (w_state_nxt == S_START) &&
                      ((r_state == S_IDLE) || (r_state == S_FAIL) ||
                       ((r_state == S_LOCKED) && !w_lost));
  assign w_timer_run = (r_state == S_WAIT_ALIGN) || (r_state == S_WAIT_DET) ||
                       (r_state == S_VERIFY) || (r_state == S_LOCKED);

  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (i_cal_req) w_state_nxt = S_START;
      S_START:      if (r_pulse_cnt == PW_LAST) w_state_nxt = S_WAIT_ALIGN;
      S_WAIT_ALIGN: begin
        if (i_align_done && r_seen_low) w_state_nxt = S_WAIT_DET;
        else if (w_align_to)            w_state_nxt = S_RETRY;
      end
      S_WAIT_DET: begin
        if (w_good)                    w_state_nxt = (LOCK_CHECKS == 1) ? S_LOCKED : S_VERIFY;
        else if (w_fault || w_det_to)  w_state_nxt = S_RETRY;
      end
      S_VERIFY: begin
        if (w_good) begin
          if (r_good_cnt == GOOD_LAST) w_state_nxt = S_LOCKED;
        end else if (w_fault || w_det_to) begin
          w_state_nxt = S_RETRY;
        end
      end
      S_LOCKED: begin
        if (w_lost)                    w_state_nxt = S_START;
        else if (!w_good && i_cal_req) w_state_nxt = S_START;
      end
      S_RETRY:      w_state_nxt = (o_retry_cnt == RETRY_MAX) ? S_FAIL : S_START;
      S_FAIL:       if (i_cal_req) w_state_nxt = S_START;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_align_start_nxt   = (w_state_nxt == S_START);
    w_busy_nxt          = (w_state_nxt == S_START) || (w_state_nxt == S_WAIT_ALIGN) ||
                          (w_state_nxt == S_WAIT_DET) || (w_state_nxt == S_VERIFY) ||
                          (w_state_nxt == S_RETRY);
    w_locked_nxt        = (w_state_nxt == S_LOCKED);
    w_cal_fail_nxt      = (w_state_nxt == S_FAIL);
    w_lost_lock_nxt     = w_lost;
    w_align_to_fclk_nxt = o_align_to_fclk;
    w_extra_shift_nxt   = o_extra_shift;
    w_retry_nxt         = o_retry_cnt;
    if (w_fresh) begin
      w_align_to_fclk_nxt = i_manual_mode;
      w_extra_shift_nxt   = i_manual_shift;
      w_retry_nxt         = 3'd0;
    end else if (w_lost) begin
      w_retry_nxt         = 3'd0;
    end else if ((r_state == S_RETRY) && (w_state_nxt == S_START)) begin
      w_retry_nxt         = o_retry_cnt + 3'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_align_start   <= 1'b0;
      o_align_to_fclk <= 1'b0;
      o_extra_shift   <= 5'd0;
      o_locked        <= 1'b0;
      o_cal_fail      <= 1'b0;
      o_busy          <= 1'b0;
      o_lost_lock     <= 1'b0;
      o_retry_cnt     <= 3'd0;
    end else begin
      o_align_start   <= w_align_start_nxt;
      o_align_to_fclk <= w_align_to_fclk_nxt;
      o_extra_shift   <= w_extra_shift_nxt;
      o_locked        <= w_locked_nxt;
      o_cal_fail      <= w_cal_fail_nxt;
      o_busy          <= w_busy_nxt;
      o_lost_lock     <= w_lost_lock_nxt;
      o_retry_cnt     <= w_retry_nxt;
    end
  end

  // Timer restarts on every state change and on every good detection, then saturates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer     <= '0;
      r_pulse_cnt <= '0;
      r_good_cnt  <= '0;
      r_seen_low  <= 1'b0;
      r_ref_shift <= 5'd0;
    end else begin
      if ((w_state_nxt != r_state) || (w_timer_run && w_good && (r_state != S_WAIT_ALIGN))) begin
        r_timer <= '0;
      end else if (w_timer_run && (r_timer != TIMER_SAT)) begin
        r_timer <= r_timer + TW'(1);
      end

      if ((w_state_nxt == S_START) && (r_state != S_START)) begin
        r_pulse_cnt <= '0;
      end else if (r_state == S_START) begin
        r_pulse_cnt <= r_pulse_cnt + PCW'(1);
      end

      if ((r_state == S_WAIT_DET) && (w_state_nxt == S_VERIFY)) begin
        r_good_cnt <= GW'(1);
      end else if ((r_state == S_VERIFY) && w_good) begin
        r_good_cnt <= r_good_cnt + GW'(1);
      end

      if (r_state != S_WAIT_ALIGN) begin
        r_seen_low <= 1'b0;
      end else if (!i_align_done) begin
        r_seen_low <= 1'b1;
      end

      if ((r_state == S_WAIT_ALIGN) && (w_state_nxt == S_WAIT_DET)) begin
        r_ref_shift <= i_shift_in;
      end
    end
  end

endmodule
